// File: rtl/kulisch_pkg.sv
// rtl/kulisch_pkg.sv - shared widths, fp16 constants and FSM state type for the Kulisch back end
package kulisch_pkg;
  localparam int WWIDTH = 79;
  localparam int VWIDTH = 12;
  localparam int AWIDTH = WWIDTH + VWIDTH;
  localparam int FBITS  = 48;
  localparam int EWIDTH = 5;
  localparam int MWIDTH = 10;
  localparam int BIAS   = 15;

  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_NORM,
    S_RND,
    S_DONE
  } state_t;
endpackage

// File: rtl/kulisch_lzc.sv
// rtl/kulisch_lzc.sv - combinational leading-one index and zero flag
module kulisch_lzc #(
  parameter int W = kulisch_pkg::AWIDTH
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] idx,
  output logic                 zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) idx = ($clog2(W))'(i);
    end
  end

  assign zero = ~|x;

endmodule

// File: rtl/kulisch_to_fp16.sv
// rtl/kulisch_to_fp16.sv - multi-cycle Kulisch accumulator to binary16 converter (RNE)
module kulisch_to_fp16
  import kulisch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AWIDTH-1:0] i_acc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_fp16,
  output logic              o_overflow,
  output logic              o_inexact
);

  localparam int PW = $clog2(AWIDTH);
  localparam int RW = EWIDTH + MWIDTH;
  // Leading-one positions bounding the normal range (e = p - FBITS in [-14, 15]).
  localparam logic [PW-1:0] P_MAX = PW'(FBITS + 15);
  localparam logic [PW-1:0] P_MIN = PW'(FBITS - 14);

  state_t state, state_nx;

  logic [AWIDTH-1:0] acc;
  logic [AWIDTH-1:0] mag;
  logic              sign;
  logic [PW-1:0]     lead, lead_q;
  logic              zero, zero_q;

  logic [PW-1:0]     sh;
  logic [AWIDTH-1:0] nrm;
  logic [EWIDTH-1:0] rexp;
  logic [MWIDTH-1:0] rfrac;
  logic              guard, sticky, big, inc;
  logic [RW-1:0]     rnd;
  logic              ovf, inx;
  logic [15:0]       res;

  kulisch_lzc #(.W(AWIDTH)) u_lzc (
    .x    (mag),
    .idx  (lead),
    .zero (zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state: fixed walk through the pipeline steps, DONE waits for downstream.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_valid) state_nx = S_ABS;
      S_ABS:   state_nx = S_NORM;
      S_NORM:  state_nx = S_RND;
      S_RND:   state_nx = S_DONE;
      S_DONE:  if (i_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_ready = (state == S_IDLE);
    o_valid = (state == S_DONE);
  end

  // Datapath registers: each step latches its own result only in its own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      mag        <= '0;
      sign       <= 1'b0;
      lead_q     <= '0;
      zero_q     <= 1'b1;
      o_fp16     <= 16'h0000;
      o_overflow <= 1'b0;
      o_inexact  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) acc <= i_acc;
        S_ABS: begin
          sign <= acc[AWIDTH-1];
          mag  <= acc[AWIDTH-1] ? -acc : acc;
        end
        S_NORM: begin
          lead_q <= lead;
          zero_q <= zero;
        end
        S_RND: begin
          o_fp16     <= res;
          o_overflow <= ovf;
          o_inexact  <= inx;
        end
        default: ;
      endcase
    end
  end

  // Field extraction and round-to-nearest-even; the shift drops the implicit one so
  // the stored fraction sits at the top of nrm and missing low bits read as zero.
  always_comb begin
    sh     = PW'(AWIDTH) - lead_q;
    nrm    = mag << sh;
    rexp   = '0;
    rfrac  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    big    = 1'b0;
    if (zero_q) begin
      big = 1'b0;
    end else if (lead_q > P_MAX) begin
      big = 1'b1;
    end else if (lead_q >= P_MIN) begin
      rexp   = EWIDTH'(lead_q - PW'(FBITS - BIAS));
      rfrac  = nrm[AWIDTH-1 -: MWIDTH];
      guard  = nrm[AWIDTH-1-MWIDTH];
      sticky = |nrm[AWIDTH-2-MWIDTH:0];
    end else begin
      rfrac  = mag[FBITS-15 -: MWIDTH];
      guard  = mag[FBITS-25];
      sticky = |mag[FBITS-26:0];
    end
    inc = guard & (sticky | rfrac[0]);
    // Carry out of the fraction lands in the exponent (subnormal->normal, max->inf).
    rnd = {rexp, rfrac} + RW'(inc);
    ovf = big | (&rnd[RW-1:MWIDTH]);
    inx = big | guard | sticky;
    if (zero_q)   res = 16'h0000;
    else if (ovf) res = sign ? FP16_NINF : FP16_PINF;
    else          res = {sign & (|rnd), rnd};
  end

endmodule

// File: tb/tb_kulisch_to_fp16.sv
// tb/tb_kulisch_to_fp16.sv - self-checking bench for kulisch_to_fp16
module tb_kulisch_to_fp16;
  localparam int AW = 91;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [AW-1:0] i_acc = '0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [15:0]   o_fp16;
  logic          o_overflow;
  logic          o_inexact;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  kulisch_to_fp16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_acc      (i_acc),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_fp16     (o_fp16),
    .o_overflow (o_overflow),
    .o_inexact  (o_inexact)
  );

  typedef struct {
    logic [AW-1:0] acc;
    logic [15:0]   fp;
    logic          ovf;
    logic          inx;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: value = acc * 2^-48, quantised to the fp16 grid at its binade
  // (quantum 2^(max(e,-14)-10)), ties to even, then encoded as a 15-bit magnitude.
  function automatic void model(input logic [AW-1:0] a, output logic [15:0] fp,
                                output logic ovf, output logic inx);
    logic [AW-1:0]  na;
    logic [127:0]   m, t, q, r, half;
    logic           s;
    int             e, eb, k, n, bits;
    s  = a[AW-1];
    na = -a;
    m  = {37'b0, (s ? na : a)};
    fp = 16'h0000; ovf = 1'b0; inx = 1'b0;
    if (m == 0) return;
    e = -48;
    t = m;
    while (t > 1) begin t = t >> 1; e++; end
    if (e > 15) begin
      fp = s ? 16'hFC00 : 16'h7C00; ovf = 1'b1; inx = 1'b1;
      return;
    end
    eb   = (e < -14) ? -14 : e;
    k    = 38 + eb;
    q    = m >> k;
    r    = m - (q << k);
    half = 128'(1) << (k - 1);
    n    = int'(q) + (((r > half) || (r == half && q[0])) ? 1 : 0);
    inx  = (r != 0);
    bits = (eb + 14) * 1024 + n;
    if (bits >= 31744) begin
      fp = s ? 16'hFC00 : 16'h7C00; ovf = 1'b1; inx = 1'b1;
    end else begin
      fp = {s && (bits != 0), bits[14:0]};
    end
  endfunction

  // Present one input, count rising edges from the accepting one until o_valid,
  // capture the result and complete the output handshake.
  task automatic convert(input logic [AW-1:0] a, output logic [15:0] fp,
                         output logic ovf, output logic inx, output int lat);
    @(negedge clk);
    i_acc = a;
    i_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_valid = 1'b0;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    fp  = o_fp16;
    ovf = o_overflow;
    inx = o_inexact;
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  vec_t          vt[14];
  logic [15:0]   fp, mfp, held;
  logic          ovf, inx, movf, minx, stable, seen;
  int            lat;
  logic [95:0]   r96;
  logic [AW-1:0] a;

  initial begin
    vt[0]  = '{AW'(1) << 48,                         16'h3C00, 1'b0, 1'b0};
    vt[1]  = '{-(AW'(1) << 48),                      16'hBC00, 1'b0, 1'b0};
    vt[2]  = '{AW'(65504) << 48,                     16'h7BFF, 1'b0, 1'b0};
    vt[3]  = '{AW'(65520) << 48,                     16'h7C00, 1'b1, 1'b1};
    vt[4]  = '{AW'(1) << 90,                         16'hFC00, 1'b1, 1'b1};
    vt[5]  = '{AW'(1) << 24,                         16'h0001, 1'b0, 1'b0};
    vt[6]  = '{AW'(1) << 23,                         16'h0000, 1'b0, 1'b1};
    vt[7]  = '{(AW'(1) << 23) + AW'(1),              16'h0001, 1'b0, 1'b1};
    vt[8]  = '{AW'(3) << 23,                         16'h0002, 1'b0, 1'b1};
    vt[9]  = '{AW'(0),                               16'h0000, 1'b0, 1'b0};
    vt[10] = '{(AW'(1023) << 24) | (AW'(1) << 23),   16'h0400, 1'b0, 1'b1};
    vt[11] = '{-(AW'(1) << 23),                      16'h0000, 1'b0, 1'b1};
    vt[12] = '{AW'(65519) << 48,                     16'h7BFF, 1'b0, 1'b1};
    vt[13] = '{-(AW'(3) << 47),                      16'hBE00, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_fp16", 64'(o_fp16), 64'd0);
    chk("reset_flags", 64'({o_overflow, o_inexact}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_o_ready", 64'(o_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      convert(vt[i].acc, fp, ovf, inx, lat);
      chk($sformatf("vec%0d_fp16", i), 64'(fp), 64'(vt[i].fp));
      chk($sformatf("vec%0d_overflow", i), 64'(ovf), 64'(vt[i].ovf));
      chk($sformatf("vec%0d_inexact", i), 64'(inx), 64'(vt[i].inx));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // Randomised magnitudes across the whole range, both signs
    for (int i = 0; i < 300; i++) begin
      r96 = {$urandom, $urandom, $urandom};
      a = r96[AW-1:0] >> $urandom_range(0, AW - 1);
      if ($urandom_range(0, 1) == 1) a = -a;
      model(a, mfp, movf, minx);
      convert(a, fp, ovf, inx, lat);
      chk($sformatf("rand%0d_fp16 acc=%0h", i, a), 64'(fp), 64'(mfp));
      chk($sformatf("rand%0d_overflow", i), 64'(ovf), 64'(movf));
      chk($sformatf("rand%0d_inexact", i), 64'(inx), 64'(minx));
    end

    // Backpressure: DONE held with stable outputs, input pulses ignored
    @(negedge clk);
    i_acc = AW'(1) << 48;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("bp_reach_done", 64'(o_valid), 64'd1);
    held = o_fp16;
    chk("bp_result", 64'(held), 64'h3C00);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      i_valid = c[0];
      i_acc = AW'(7) << 50;
      @(posedge clk);
      @(negedge clk);
      stable &= o_valid && !o_ready && (o_fp16 == held);
    end
    i_valid = 1'b0;
    chk("bp_stable", 64'(stable), 64'd1);
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready = 1'b0;
    chk("bp_release_valid", 64'(o_valid), 64'd0);
    chk("bp_release_ready", 64'(o_ready), 64'd1);
    chk("bp_hold_after", 64'(o_fp16), 64'h3C00);
    model(-(AW'(5) << 46), mfp, movf, minx);
    convert(-(AW'(5) << 46), fp, ovf, inx, lat);
    chk("bp_next_fp16", 64'(fp), 64'(mfp));
    chk("bp_next_latency", 64'(lat), 64'd4);

    // Reset during NORM: abort, clear outputs, no stale result
    @(negedge clk);
    i_acc = AW'(1) << 48;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_fp16", 64'(o_fp16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seen |= o_valid;
    end
    chk("rst_no_stale", 64'(seen), 64'd0);
    convert(AW'(0), fp, ovf, inx, lat);
    chk("rst_zero_fp16", 64'(fp), 64'd0);
    chk("rst_zero_flags", 64'({ovf, inx}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
